// File: rtl/mem_mmio.sv
// rtl/mem_mmio.sv - word RAM plus memory-mapped display, switch, button, timer and interrupt registers
module mem_mmio #(
  parameter int          RAM_WORDS  = 64,
  parameter int          SW_WIDTH   = 8,
  parameter int          BTN_COUNT  = 1,
  parameter int          DISP_WIDTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hC000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [31:0]           a,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic [BTN_COUNT-1:0]  button,
  output logic [DISP_WIDTH-1:0] deco_displays_seven_segments,
  output logic                  irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]           r_ram [RAM_WORDS];
  logic [DISP_WIDTH-1:0] r_disp;
  logic [SW_WIDTH-1:0]   r_sw_s1, r_sw_s2;
  logic [BTN_COUNT-1:0]  r_btn_s1, r_btn_s2, r_btn_prev, r_btn_edge;
  logic [31:0]           r_timer, r_timer_cmp;
  logic [2:0]            r_status;
  logic [3:0]            r_irq_en;
  logic                  r_irq;

  logic [31:0]          w_io_off;
  logic [2:0]           w_io_idx;
  logic                 w_is_io, w_is_ram, w_mapped, w_misal;
  logic                 w_wr_io, w_wr_ram;
  logic [7:0]           w_sel;
  logic [2:0]           w_status_set, w_status_clr;
  logic [BTN_COUNT-1:0] w_edge_set, w_edge_clr;

  // The I/O window takes precedence should it ever overlap RAM space.
  assign w_io_off = a - IO_BASE;
  assign w_io_idx = w_io_off[4:2];
  assign w_is_io  = (w_io_off < 32'd32);
  assign w_is_ram = !w_is_io && (a < RAM_BYTES);
  assign w_mapped = w_is_io || w_is_ram;
  assign w_misal  = |a[1:0];
  assign w_wr_io  = we && w_is_io && !w_misal;
  assign w_wr_ram = we && w_is_ram && !w_misal;
  assign w_sel    = w_wr_io ? (8'd1 << w_io_idx) : 8'd0;

  assign w_status_set = {we && !w_mapped, we && w_misal, r_timer == r_timer_cmp};
  assign w_status_clr = w_sel[6] ? wd[2:0] : 3'd0;
  assign w_edge_set   = r_btn_s2 & ~r_btn_prev;
  assign w_edge_clr   = w_sel[3] ? wd[BTN_COUNT-1:0] : '0;

  assign deco_displays_seven_segments = r_disp;
  assign irq = r_irq;

  always_comb begin
    rd = 32'd0;
    if (w_is_io) begin
      case (w_io_idx)
        3'd0:    rd = 32'(r_disp);
        3'd1:    rd = 32'(r_btn_s2);
        3'd2:    rd = 32'(r_sw_s2);
        3'd3:    rd = 32'(r_btn_edge);
        3'd4:    rd = r_timer;
        3'd5:    rd = r_timer_cmp;
        3'd6:    rd = {29'd0, r_status};
        default: rd = {28'd0, r_irq_en};
      endcase
    end else if (w_is_ram) begin
      rd = r_ram[a[AW+1:2]];
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ram && !reset) r_ram[a[AW+1:2]] <= wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp      <= '0;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_btn_s1    <= '0;
      r_btn_s2    <= '0;
      r_btn_prev  <= '0;
      r_btn_edge  <= '0;
      r_timer     <= 32'd0;
      r_timer_cmp <= 32'hFFFF_FFFF;
      r_status    <= 3'd0;
      r_irq_en    <= 4'd0;
      r_irq       <= 1'b0;
    end else begin
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= button;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
      // Set wins over a simultaneous write-one-to-clear.
      r_btn_edge <= (r_btn_edge & ~w_edge_clr) | w_edge_set;
      r_status   <= (r_status & ~w_status_clr) | w_status_set;
      r_timer    <= w_sel[4] ? wd : r_timer + 32'd1;
      if (w_sel[0]) r_disp      <= wd[DISP_WIDTH-1:0];
      if (w_sel[5]) r_timer_cmp <= wd;
      if (w_sel[7]) r_irq_en    <= wd[3:0];
      r_irq <= |(r_irq_en[2:0] & r_status) | (r_irq_en[3] & |r_btn_edge);
    end
  end

endmodule

// File: tb/tb_mem_mmio.sv
// tb/tb_mem_mmio.sv - directed self-checking bench for mem_mmio
module tb_mem_mmio;

  localparam logic [31:0] IOB = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [31:0] a, wd, rd;
  logic [7:0]  sw;
  logic [0:0]  button;
  logic [7:0]  disp;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  mem_mmio dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
    .sw(sw), .button(button), .deco_displays_seven_segments(disp), .irq(irq)
  );

  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0; sw = 8'd0; button = 1'b0;
    #1;
    n_checks++; if (disp !== 8'd0) begin n_fail++; $display("FAIL rst_disp got %h exp 00", disp); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b exp 0", irq); end
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_timer got %h exp 0", v); end
    peek(IOB + 32'h14, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp got %h exp ffffffff", v); end
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_status got %h exp 0", v); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL timer_start got %h exp 1", v); end
  endtask

  task automatic test_ram;
    wr(32'h20, 32'h1234_5678);
    peek(32'h20, v);
    n_checks++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_20 got %h exp 12345678", v); end
    wr(32'hFC, 32'hDEAD_BEEF);
    peek(32'hFC, v);
    n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_fc got %h exp deadbeef", v); end
    peek(32'h100, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ram_oob got %h exp 0", v); end
    peek(32'h20, v);
    n_checks++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_20_keep got %h exp 12345678", v); end
  endtask

  task automatic test_disp;
    wr(IOB, 32'h8);
    n_checks++; if (disp !== 8'h08) begin n_fail++; $display("FAIL disp_out got %h exp 08", disp); end
    peek(IOB, v);
    n_checks++; if (v !== 32'h8) begin n_fail++; $display("FAIL disp_rd got %h exp 8", v); end
  endtask

  task automatic test_sw;
    @(negedge clk); sw = 8'hA5;
    @(negedge clk);
    peek(IOB + 32'h8, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL sw_lat1 got %h exp 0", v); end
    @(negedge clk);
    peek(IOB + 32'h8, v);
    n_checks++; if (v !== 32'hA5) begin n_fail++; $display("FAIL sw_lat2 got %h exp a5", v); end
  endtask

  task automatic test_button;
    @(negedge clk); button = 1'b1;
    @(negedge clk);
    peek(IOB + 32'h4, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL btn_n1 got %h exp 0", v); end
    @(negedge clk);
    peek(IOB + 32'h4, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL btn_n2 got %h exp 1", v); end
    peek(IOB + 32'hC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL edge_n2 got %h exp 0", v); end
    @(negedge clk);
    peek(IOB + 32'hC, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL edge_n3 got %h exp 1", v); end
    wr(IOB + 32'hC, 32'h1);
    peek(IOB + 32'hC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL edge_w1c got %h exp 0", v); end
    @(negedge clk); button = 1'b0;
    repeat (4) @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    @(negedge clk);
    we = 1'b1; a = IOB + 32'hC; wd = 32'h1;
    @(negedge clk);
    we = 1'b0;
    peek(IOB + 32'hC, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL edge_set_wins got %h exp 1", v); end
    wr(IOB + 32'hC, 32'h1);
    peek(IOB + 32'hC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL edge_clr2 got %h exp 0", v); end
  endtask

  task automatic test_errors;
    wr(IOB + 32'h18, 32'h7);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL status_clr got %h exp 0", v); end
    wr(32'h0000_1000, 32'h55);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL status_unmapped got %h exp 4", v); end
    peek(32'h0000_1000, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_rd got %h exp 0", v); end
    wr(32'h22, 32'hAAAA);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'h6) begin n_fail++; $display("FAIL status_misal got %h exp 6", v); end
    peek(32'h20, v);
    n_checks++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL misal_nowrite got %h exp 12345678", v); end
    wr(IOB + 32'h18, 32'h2);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL status_partial got %h exp 4", v); end
    wr(IOB + 32'h18, 32'h4);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL status_clr2 got %h exp 0", v); end
  endtask

  task automatic test_timer;
    wr(IOB + 32'h14, 32'h0);
    wr(IOB + 32'h1C, 32'h1);
    wr(IOB + 32'h10, 32'hFFFF_FFFE);
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_load got %h exp fffffffe", v); end
    @(negedge clk);
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_inc got %h exp ffffffff", v); end
    @(negedge clk);
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL timer_wrap got %h exp 0", v); end
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL match_early got %h exp 0", v); end
    @(negedge clk);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL match_set got %h exp 1", v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
    wr(IOB + 32'h18, 32'h1);
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b exp 0", irq); end
    wr(IOB + 32'h14, 32'h100);
    wr(IOB + 32'h10, 32'h100);
    @(negedge clk);
    peek(IOB + 32'h18, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL match_direct got %h exp 1", v); end
    wr(IOB + 32'h18, 32'h1);
  endtask

  task automatic test_async_reset;
    wr(IOB + 32'h1C, 32'h2);
    wr(32'h1, 32'h0);
    wr(IOB, 32'hFF);
    wr(IOB + 32'h10, 32'h50);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_irq got %b exp 1", irq); end
    n_checks++; if (disp !== 8'hFF) begin n_fail++; $display("FAIL pre_disp got %h exp ff", disp); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (disp !== 8'h00) begin n_fail++; $display("FAIL arst_disp got %h exp 00", disp); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq got %b exp 0", irq); end
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL arst_timer got %h exp 0", v); end
    peek(IOB + 32'h14, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL arst_cmp got %h exp ffffffff", v); end
    we = 1'b1; a = IOB; wd = 32'hAA;
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    peek(IOB, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL arst_wr_lost got %h exp 0", v); end
    @(negedge clk);
    peek(IOB + 32'h10, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL arst_resume got %h exp 1", v); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_disp();
    test_sw();
    test_button();
    test_errors();
    test_timer();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_mmio.md
MEM_MMIO -- requirements
Module: mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, number of 32-bit RAM words (power of two, 4..1024).
REQ-002 SHALL have parameter SW_WIDTH, default 8, switch input width (1..32).
REQ-003 SHALL have parameter BTN_COUNT, default 1, button input count (1..16).
REQ-004 SHALL have parameter DISP_WIDTH, default 8, display output width (1..32).
REQ-005 SHALL have parameter IO_BASE, default 32'hC000_0000, base of the I/O register window.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), reset input 1 (asynchronous, active-high).
REQ-007 SHALL have ports: we input 1 (write enable); a input 32 (byte address); wd input 32 (write data); rd output 32 (read data).
REQ-008 SHALL have ports: sw input SW_WIDTH (raw switches); button input BTN_COUNT (raw buttons); deco_displays_seven_segments output DISP_WIDTH (display register); irq output 1 (OR of enabled sticky flags).

Function
REQ-009 SHALL decode the I/O window IO_BASE+0x00..0x1C and RAM space a < 4*RAM_WORDS; all other addresses are unmapped.
REQ-010 SHALL map registers: 0x00 DISP (RW); 0x04 BTN level (RO); 0x08 SW level (RO); 0x0C BTN_EDGE (W1C); 0x10 TIMER (RW); 0x14 TIMER_CMP (RW); 0x18 STATUS (W1C); 0x1C IRQ_EN (RW).
REQ-011 SHALL produce rd combinationally from a in the same cycle; unused upper bits read 0.
REQ-012 SHALL write RAM word a[log2(RAM_WORDS)+1:2] on the rising clk edge when we=1 and a is in RAM space; RAM contents are not reset.
REQ-013 SHALL ignore a[1:0] for decoding; a non-zero a[1:0] with we=1 sets STATUS bit1 (misaligned) and performs no write.
REQ-014 SHALL, for unmapped addresses, return rd=0; we=1 sets STATUS bit2 (unmapped) and performs no write.
REQ-015 SHALL drive deco_displays_seven_segments directly from DISP; DISP reads back its current value.
REQ-016 SHALL pass sw and button through a 2-flop synchronizer each; BTN and SW reads return the synchronized values (2-cycle latency from pad).
REQ-017 SHALL set BTN_EDGE[i] on a 0->1 transition of synchronized button[i] (one cycle after REQ-016's visibility); flags are sticky.
REQ-018 SHALL clear BTN_EDGE/STATUS bits written as 1; bits written as 0 are unchanged; a set event in the same cycle as its clear leaves the bit set.
REQ-019 SHALL increment TIMER by 1 every cycle, wrapping 0xFFFF_FFFF -> 0; a write loads wd, and the write takes priority over the increment in that cycle.
REQ-020 SHALL set STATUS bit0 in the cycle after TIMER equals TIMER_CMP, including a match reached by wrap or by a direct TIMER write.
REQ-021 SHALL assert irq = |(IRQ_EN[2:0] & STATUS[2:0]) | (IRQ_EN[3] & |BTN_EDGE), registered, one cycle after the flag sets.
REQ-022 SHALL treat we=0 as a pure read with no side effects; reads never clear flags.

Reset
REQ-023 SHALL, on reset=1 and independent of clk, clear DISP, BTN_EDGE, TIMER, STATUS, IRQ_EN, irq, and synchronizer flops, and set TIMER_CMP to 0xFFFF_FFFF.
REQ-024 SHALL, after reset deasserts mid-operation, resume counting from 0 on the first rising edge; a write in the reset cycle is lost.

Verification
REQ-025 SHALL pass: write 0x12345678 to RAM 0x20, read 0x20 -> 0x12345678; write 0x8 to IO_BASE -> display=0x08, read IO_BASE -> 0x08.
REQ-026 SHALL pass: button 0->1 at cycle N -> BTN read=1 at N+2, BTN_EDGE[0]=1 at N+3; W1C 0x1 -> 0; W1C coinciding with new edge -> stays 1.
REQ-027 SHALL pass: write TIMER=0xFFFF_FFFE, TIMER_CMP=0x0, IRQ_EN=0x1 -> TIMER wraps, STATUS bit0=1 one cycle after TIMER=0, irq=1 the cycle after.
REQ-028 SHALL pass: write to address 0x0000_1000 -> STATUS bit2=1, read returns 0; write to 0x22 -> STATUS bit1=1, RAM unchanged.
REQ-029 SHALL pass: assert reset between clk edges while TIMER=0x50 and DISP=0xFF -> both 0 immediately, TIMER_CMP=0xFFFF_FFFF, irq=0.
